// File: rtl/sipo_pkg.sv
// Shared types for the serial-in/parallel-out deserializer.
package sipo_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
    localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter; word/word_done are valid combinationally on the completing edge.
// No backpressure: every sin_valid bit is accepted, and frame_sync restarts the word at bit 0.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sin,
    input  logic                         sin_valid,
    input  logic                         frame_sync,
    output logic [WIDTH-1:0]             word,
    output logic                         word_done,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d, base;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             restart;

    always_comb begin
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
        restart   = frame_sync || (cnt_q == '0);
        // A restart builds on an empty register so no stale bits leak into the word.
        base      = restart ? '0 : sr_q;
        if (sin_valid) begin
            if (MSB_FIRST) sr_d = {base[WIDTH-2:0], sin};
            else           sr_d = {sin, base[WIDTH-1:1]};
            if (restart) begin
                cnt_d = CW'(1);
            end else if (cnt_q == LAST) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign word    = sr_d;
    assign bit_cnt = cnt_q;
endmodule

// File: rtl/sipo_deser.sv
// Deserializer top: word visible the cycle after its last bit; one-entry holding register with
// valid/ready; a word completing while the register is full and not draining is dropped (sticky overrun).
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sin,
    input  logic                         sin_valid,
    input  logic                         frame_sync,
    output logic [WIDTH-1:0]             dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic                         overrun,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d, word;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;
    logic             word_done, drain;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .frame_sync (frame_sync),
        .word       (word),
        .word_done  (word_done),
        .bit_cnt    (bit_cnt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sin_valid) state_d = SHIFT;
            SHIFT:   if (word_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
        drain        = dout_valid_q && dout_ready;
        if (word_done) begin
            // A drain on the same edge frees the slot, so the new word still fits.
            if (!dout_valid_q || dout_ready) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (drain) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench: an MSB-first and an LSB-first instance share one serial stimulus.
module tb_sipo_deser;
    logic       clk;
    logic       rst, sin, sin_valid, frame_sync, dout_ready;
    logic [7:0] dout_m, dout_l;
    logic       vld_m, vld_l, ovr_m, ovr_l;
    logic [3:0] cnt_m, cnt_l;

    int n_cmp = 0;
    int n_err = 0;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .frame_sync(frame_sync),
        .dout(dout_m), .dout_valid(vld_m), .dout_ready(dout_ready), .overrun(ovr_m), .bit_cnt(cnt_m)
    );
    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .frame_sync(frame_sync),
        .dout(dout_l), .dout_valid(vld_l), .dout_ready(dout_ready), .overrun(ovr_l), .bit_cnt(cnt_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, sin, sv, fs, rdy;
        logic       e_vld;
        logic [7:0] e_dout_m, e_dout_l;
        logic       e_ovr;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic tick(input logic r, input logic s, input logic v, input logic f, input logic d);
        rst = r; sin = s; sin_valid = v; frame_sync = f; dout_ready = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) y[i] = x[7-i];
        return y;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_dout_m"}, 32'(dout_m), 32'h0);
        chk({tag, "_dout_l"}, 32'(dout_l), 32'h0);
        chk({tag, "_vld"},    32'(vld_m),  32'h0);
        chk({tag, "_cnt"},    32'(cnt_m),  32'h0);
        chk({tag, "_ovr"},    32'(ovr_m),  32'h0);
    endtask

    initial begin
        logic [7:0] b1, wa, wb, wr, wg;
        int         nvld;

        rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; frame_sync = 1'b0; dout_ready = 1'b0;

        // Reset + basic word: 1,0,1,1,0,0,1,0 -> B2 (MSB first), 4D (LSB first).
        b1 = 8'hB2;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0};
        for (int i = 0; i < 7; i++)
            tbl[2+i] = '{1'b0, b1[7-i], 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'(i+1)};
        tbl[9]  = '{1'b0, b1[0], 1'b1, 1'b0, 1'b1, 1'b1, 8'hB2, 8'h4D, 1'b0, 4'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b0, 4'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b0, 4'd0};

        for (int i = 0; i < 12; i++) begin
            tick(tbl[i].rst, tbl[i].sin, tbl[i].sv, tbl[i].fs, tbl[i].rdy);
            chk($sformatf("v%0d_dout_m", i), 32'(dout_m), 32'(tbl[i].e_dout_m));
            chk($sformatf("v%0d_dout_l", i), 32'(dout_l), 32'(tbl[i].e_dout_l));
            chk($sformatf("v%0d_vld_m", i),  32'(vld_m),  32'(tbl[i].e_vld));
            chk($sformatf("v%0d_vld_l", i),  32'(vld_l),  32'(tbl[i].e_vld));
            chk($sformatf("v%0d_ovr", i),    32'(ovr_m),  32'(tbl[i].e_ovr));
            chk($sformatf("v%0d_cnt", i),    32'(cnt_m),  32'(tbl[i].e_cnt));
        end

        // Backpressure: FF then 00 with ready low; the second word is dropped.
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, (i < 8), 1'b1, 1'b0, 1'b0);
            if (i >= 7) begin
                chk($sformatf("bp%0d_vld", i),    32'(vld_m),  32'h1);
                chk($sformatf("bp%0d_dout_m", i), 32'(dout_m), 32'hFF);
            end
            chk($sformatf("bp%0d_ovr", i), 32'(ovr_m), 32'(i == 15));
        end
        chk("bp_ovr_l", 32'(ovr_l), 32'h1);
        chk("bp_dout_l", 32'(dout_l), 32'hFF);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_drain_vld", 32'(vld_m), 32'h0);
        chk("bp_ovr_sticky", 32'(ovr_m), 32'h1);

        // Drain on the completion edge of word B: A -> B with no gap in valid.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_zero("rst2");
        wa = 8'hFF;
        wb = 8'hC5;
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, (i < 8) ? wa[7-i] : wb[15-i], 1'b1, 1'b0, (i == 15));
            if (i >= 7 && i < 15) chk($sformatf("dr%0d_dout_m", i), 32'(dout_m), 32'(wa));
            if (i >= 7) chk($sformatf("dr%0d_vld", i), 32'(vld_m), 32'h1);
        end
        chk("dr_dout_m", 32'(dout_m), 32'(wb));
        chk("dr_dout_l", 32'(dout_l), 32'(rev8(wb)));
        chk("dr_ovr", 32'(ovr_m), 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("dr_done_vld", 32'(vld_m), 32'h0);

        // Resync and gaps: 3 junk bits, sync bit, then 7 bits spaced by 2 idle cycles.
        wg = 8'h96;
        nvld = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, (i != 0), 1'b1, 1'b0, 1'b1);
            chk($sformatf("rs_pre%0d_cnt", i), 32'(cnt_m), 32'(i + 1));
        end
        tick(1'b0, wg[7], 1'b1, 1'b1, 1'b1);
        chk("rs_sync_cnt", 32'(cnt_m), 32'h1);
        chk("rs_sync_ovr", 32'(ovr_m), 32'h0);
        for (int i = 1; i < 8; i++) begin
            tick(1'b0, wg[7-i], 1'b1, 1'b0, 1'b1);
            nvld += int'(vld_m);
            if (i == 7) begin
                chk("rs_dout_m", 32'(dout_m), 32'(wg));
                chk("rs_dout_l", 32'(dout_l), 32'(rev8(wg)));
            end
            for (int g = 0; g < 2; g++) begin
                tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
                nvld += int'(vld_m);
                chk($sformatf("rs_gap%0d_%0d_cnt", i, g), 32'(cnt_m), 32'((i + 1) % 8));
            end
        end
        chk("rs_one_word", 32'(nvld), 32'h1);

        // Reset with a held word and a 5-bit partial word, then a clean word.
        wr = 8'hA5;
        for (int i = 0; i < 13; i++) tick(1'b0, (i < 8) ? wr[7-i] : 1'b1, 1'b1, 1'b0, 1'b0);
        chk("mr_pre_vld", 32'(vld_m), 32'h1);
        chk("mr_pre_cnt", 32'(cnt_m), 32'h5);
        chk("mr_pre_dout", 32'(dout_m), 32'(wr));
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_zero("mr_rst");
        wr = 8'h3E;
        for (int i = 0; i < 8; i++) tick(1'b0, wr[7-i], 1'b1, 1'b0, 1'b1);
        chk("mr_vld", 32'(vld_m), 32'h1);
        chk("mr_dout_m", 32'(dout_m), 32'(wr));
        chk("mr_dout_l", 32'(dout_l), 32'(rev8(wr)));
        chk("mr_ovr", 32'(ovr_m), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in/parallel-out deserializer that consumes the registered single-bit stream produced by the team's synchronous-reset D flip-flop stage and assembles it into WIDTH-bit words. Words are presented downstream through a one-entry holding register with a valid/ready handshake. Words that complete while that register is still full are dropped and flagged. Frame alignment is controlled by an explicit sync strobe.

## Interface
- WIDTH, 8, bits per assembled word (2..32)
- MSB_FIRST, 1, 1: the first received bit lands in dout[WIDTH-1]; 0: the first received bit lands in dout[0]
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high; clock clk
- sin  input  1  serial data bit (registered DFF output)
- sin_valid  input  1  sin is sampled on this edge
- frame_sync  input  1  qualified by sin_valid; the current bit is bit 0 of a new word
- dout  output  WIDTH  assembled word; stable while dout_valid=1
- dout_valid  output  1  holding register full
- dout_ready  input  1  downstream accepts dout on this edge when dout_valid=1
- overrun  output  1  sticky; a completed word was dropped
- bit_cnt  output  $clog2(WIDTH+1)  bits collected in the current partial word

## Operation
- The FSM has two states.
  - IDLE: bit_cnt=0.
  - SHIFT: 0 < bit_cnt < WIDTH.
- IDLE -> SHIFT: on sin_valid, the bit is shifted in and bit_cnt becomes 1.
  - Exception: if WIDTH=... does not apply; WIDTH≥2, so one bit never completes a word.
- SHIFT, sin_valid, frame_sync=0: shift the bit in and increment bit_cnt. If this bit is bit WIDTH-1, the word completes, bit_cnt returns to 0 and the state returns to IDLE.
- SHIFT, sin_valid, frame_sync=1: discard the partial word. The current bit becomes bit 0 and bit_cnt becomes 1. overrun is not set.
- sin_valid=0: shift register and bit_cnt hold.
- Word completion when the holding register is empty, or is being drained this edge (dout_valid & dout_ready): load dout and set dout_valid=1.
- Word completion when the holding register is full and not being drained: drop the new word, keep dout unchanged, and set overrun=1.
- overrun is cleared only by rst.
- Handshake:
  - dout_valid & dout_ready with no completion on the same edge clears dout_valid.
  - dout_valid never drops without a handshake.
  - dout never changes while dout_valid=1 unless it is drained on the same edge.
- Reset values (rst=1 on a rising edge): dout=0, dout_valid=0, overrun=0, bit_cnt=0, state=IDLE, shift register=0. rst has priority over every other input.
- Reset mid-word: the partial word is lost. The next sin_valid starts a new word at bit 0.

## Timing
- Serial input: one bit per edge at most. Back-to-back sin_valid is supported at full rate, giving one word every WIDTH cycles.
- Latency: the word whose last bit is sampled on edge N has dout_valid=1 and dout stable in the cycle after edge N.
- Downstream may hold dout_ready low for up to WIDTH-1 cycles without loss at full input rate.
- Simultaneous drain and completion on the same edge: dout_valid stays 1 and dout shows the new word.
- bit_cnt is registered and reflects bits accepted up to the previous edge.
- No combinational path from any input to any output.

## Structure
- Package sipo_pkg holds:
  - the state enum {IDLE, SHIFT};
  - localparam DEF_WIDTH=8.
- One sub-module, sipo_shift_core:
  - contents: the shift register and bit counter;
  - inputs: clk, rst, sin, sin_valid, frame_sync;
  - outputs: word, word_done (1-cycle pulse), bit_cnt.
- The top level holds the FSM, the holding register, the handshake and overrun.

## Test plan
- Reset and basic shift, MSB_FIRST=1, WIDTH=8:
  - Stimulus: rst for 2 cycles, then bits 1,0,1,1,0,0,1,0 on consecutive sin_valid with dout_ready=1.
  - Required: dout=8'hB2, dout_valid high for exactly 1 cycle after the 8th bit edge, overrun=0.
- LSB first:
  - Stimulus: MSB_FIRST=0, same bit sequence.
  - Required: dout=8'h4D.
- Backpressure and overrun:
  - Stimulus: dout_ready=0, stream 16 continuous bits (word A=8'hFF, word B=8'h00).
  - Required: dout stays 8'hFF, dout_valid stays 1, overrun=1 after the 16th bit. Raising dout_ready then clears dout_valid on the next edge.
- Drain on the completion edge:
  - Stimulus: dout_ready pulsed on the same edge as the last bit of word B.
  - Required: dout changes directly from A to B, dout_valid never drops, overrun=0.
- Resync and gaps:
  - Stimulus: 3 bits, then frame_sync with sin_valid, then 7 more bits with sin_valid gaps of 2 idle cycles.
  - Required: bit_cnt goes 3 -> 1 -> 8 bits total; exactly one word is output, built from the sync bit onward.
- Reset mid-word and mid-hold:
  - Stimulus: rst asserted with dout_valid=1 and bit_cnt=5.
  - Required: after the edge, dout=0, dout_valid=0, bit_cnt=0, overrun=0. The next 8 bits form a clean word.
